echo_sequence_engine: RTL and testbench
=======================================

// Module: echo_sequence_engine
// PURPOSE
//   Parametrised memory-game engine (Simon-style) for the piezo/LED game path.
//   Plays the first cur_len notes of a loaded sequence with fixed note/gap timing, then checks player answers
//   note by note, grows the sequence on success, replays it on a miss, and ends the game in WON or LOST.
//   Sits between the input/keypad front end and the piezo/LED drivers; replaces the fixed 8x4-bit game block.
// PARAMETERS
//   NOTE_W      4   bits per note (piezo/LED code)
//   MAX_LEN     8   sequence capacity in notes (>=2)
//   START_LEN   3   notes played in the first round (1..MAX_LEN)
//   TICK_DIV    3   clk cycles per timing tick (>=1)
//   NOTE_TICKS  2   ticks a note is sounded
//   GAP_TICKS   1   ticks of silence after each note and before a replay
//   ANS_TICKS   16  ticks allowed per answer before timeout
//   MAX_MISSES  3   misses that end the game (>=1)
//   IDX_W = $clog2(MAX_LEN), LEN_W = $clog2(MAX_LEN+1), MISS_W = $clog2(MAX_MISSES+1) (localparams)
// PORTS
//   clk          in   1                clock
//   reset        in   1                async reset, active-low
//   load_valid   in   1                load sequence (accepted in IDLE/WON/LOST only)
//   load_data    in   NOTE_W*MAX_LEN   note i at [i*NOTE_W +: NOTE_W]
//   start        in   1                begin game (accepted in IDLE with a sequence loaded)
//   clear        in   1                sync abort -> IDLE, sequence kept
//   ans_valid    in   1                one-cycle answer strobe
//   ans_data     in   NOTE_W           answered note
//   note_out     out  NOTE_W           note to piezo/LED; 0 when silent
//   playing      out  1                high in PLAY_ON/PLAY_GAP
//   expect_input out  1                high in WAIT_ANS
//   hit          out  1                1-cycle pulse: correct answer
//   miss         out  1                1-cycle pulse: wrong answer or timeout
//   round_done   out  1                1-cycle pulse: full round answered correctly
//   game_won     out  1                level, high in WON
//   game_over    out  1                level, high in LOST
//   cur_len      out  LEN_W            notes in current round
//   miss_count   out  MISS_W           misses so far this game
// BEHAVIOUR
//   Reset (reset=0, async): state IDLE, sequence regs 0, loaded=0, all outputs 0, cur_len=START_LEN.
//   States: IDLE, PLAY_ON, PLAY_GAP, WAIT_ANS, WON, LOST. All outputs registered.
//   Priority per cycle: clear > load_valid > start > ans_valid. clear in any state -> IDLE next cycle,
//     note_out=0, cur_len=START_LEN, miss_count=0, loaded unchanged.
//   Load: in IDLE/WON/LOST, stores load_data, loaded=1, state -> IDLE; ignored in PLAY_*/WAIT_ANS.
//   Start: same-cycle load+start -> start dropped. Start with loaded=0 ignored. Accepted at edge N:
//     idx=0, cur_len=START_LEN, miss_count=0, tick divider cleared, PLAY_ON from N+1.
//   PLAY_ON: note_out=seq[idx] for NOTE_TICKS*TICK_DIV cycles (6 default), then PLAY_GAP.
//   PLAY_GAP: note_out=0 for GAP_TICKS*TICK_DIV cycles; then idx<cur_len-1 -> idx+1, PLAY_ON;
//     else idx=0, answer timer cleared, WAIT_ANS. Tick divider restarts on every state entry.
//   WAIT_ANS: ans_valid compares ans_data with seq[idx]; hit/miss pulse on the next cycle.
//     Match, idx<cur_len-1: idx+1, timer cleared, stay.
//     Match, idx=cur_len-1: round_done pulse; cur_len=MAX_LEN -> WON; else cur_len+1, idx=0, PLAY_GAP (replay lead-in).
//     Mismatch or timer reaching ANS_TICKS ticks: miss pulse, miss_count+1; new count=MAX_MISSES -> LOST;
//       else idx=0, same cur_len, PLAY_GAP then replay.
//   hit and round_done pulse together on the final correct note.
//   ans_valid outside WAIT_ANS ignored (no miss, no count).
//   WON/LOST: note_out=0, hold until start (replay same sequence), load_valid or clear.
//   Widths: idx wraps never (bounded by cur_len); miss_count saturates at MAX_MISSES.
// TESTING
//   Defaults, load 0x87654321, start -> note_out 1,2,3 each 6 cycles with 3-cycle 0 gaps, expect_input after.
//   Answer 1,2,3 -> hit x3, round_done on 3rd, replay of 1,2,3,4 after a 3-cycle gap, cur_len=4.
//   Answer 1,5 in round 1 -> miss, miss_count=1, replay 1,2,3; 3 total misses -> game_over=1, note_out=0.
//   No answer for 48 cycles in WAIT_ANS -> miss pulse, miss_count=1, replay starts.
//   Correct rounds through cur_len=8 -> round_done then game_won=1; load+start same cycle -> start ignored.
//   reset low mid PLAY_ON -> all outputs 0 at once; clear mid WAIT_ANS -> IDLE, start replays the kept sequence.

Source files
------------

// File: rtl/echo_sequence_engine.sv
// Simon-style memory game engine: plays a growing prefix of a loaded note sequence,
// then scores player answers with per-answer timeout, miss budget and win/lose end states.
module echo_sequence_engine #(
    parameter int NOTE_W     = 4,
    parameter int MAX_LEN    = 8,
    parameter int START_LEN  = 3,
    parameter int TICK_DIV   = 3,
    parameter int NOTE_TICKS = 2,
    parameter int GAP_TICKS  = 1,
    parameter int ANS_TICKS  = 16,
    parameter int MAX_MISSES = 3,
    localparam int IDX_W  = $clog2(MAX_LEN),
    localparam int LEN_W  = $clog2(MAX_LEN + 1),
    localparam int MISS_W = $clog2(MAX_MISSES + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_valid,
    input  logic [NOTE_W*MAX_LEN-1:0] load_data,
    input  logic                      start,
    input  logic                      clear,
    input  logic                      ans_valid,
    input  logic [NOTE_W-1:0]         ans_data,
    output logic [NOTE_W-1:0]         note_out,
    output logic                      playing,
    output logic                      expect_input,
    output logic                      hit,
    output logic                      miss,
    output logic                      round_done,
    output logic                      game_won,
    output logic                      game_over,
    output logic [LEN_W-1:0]          cur_len,
    output logic [MISS_W-1:0]         miss_count
);
    localparam int MAX_T  = (ANS_TICKS > NOTE_TICKS) ?
                            ((ANS_TICKS > GAP_TICKS) ? ANS_TICKS : GAP_TICKS) :
                            ((NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS);
    localparam int TCNT_W = $clog2(MAX_T + 1);
    localparam int DIV_W  = $clog2(TICK_DIV + 1);

    typedef enum logic [2:0] {S_IDLE, S_PLAY_ON, S_PLAY_GAP, S_WAIT_ANS, S_WON, S_LOST} state_t;

    state_t                       state, nxt_state;
    logic [IDX_W-1:0]             idx, nxt_idx;
    logic [LEN_W-1:0]             len_q, nxt_len;
    logic [MISS_W-1:0]            miss_q, nxt_miss;
    logic [MAX_LEN-1:0][NOTE_W-1:0] seq, nxt_seq;
    logic                         loaded, nxt_loaded;
    logic                         lead, nxt_lead;
    logic                         tmr_clr;
    logic [DIV_W-1:0]             div;
    logic [TCNT_W-1:0]            tcnt;
    logic                         tick, idle_like, timed, last_note;
    logic                         hit_n, miss_n, rd_n;

    assign tick      = (div == DIV_W'(TICK_DIV - 1));
    assign idle_like = (state == S_IDLE) || (state == S_WON) || (state == S_LOST);
    assign timed     = (state == S_PLAY_ON) || (state == S_PLAY_GAP) || (state == S_WAIT_ANS);
    assign last_note = ((LEN_W'(idx) + LEN_W'(1)) == len_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            idx    <= '0;
            len_q  <= LEN_W'(START_LEN);
            miss_q <= '0;
            seq    <= '0;
            loaded <= 1'b0;
            lead   <= 1'b0;
            div    <= '0;
            tcnt   <= '0;
        end else begin
            state  <= nxt_state;
            idx    <= nxt_idx;
            len_q  <= nxt_len;
            miss_q <= nxt_miss;
            seq    <= nxt_seq;
            loaded <= nxt_loaded;
            lead   <= nxt_lead;
            // Divider and tick count restart on every state entry; a correct answer only rearms the tick count.
            if (nxt_state != state || !timed) begin
                div  <= '0;
                tcnt <= '0;
            end else begin
                div <= tick ? '0 : div + DIV_W'(1);
                if (tmr_clr)   tcnt <= '0;
                else if (tick) tcnt <= tcnt + TCNT_W'(1);
            end
        end
    end

    always_comb begin
        nxt_state  = state;
        nxt_idx    = idx;
        nxt_len    = len_q;
        nxt_miss   = miss_q;
        nxt_seq    = seq;
        nxt_loaded = loaded;
        nxt_lead   = lead;
        tmr_clr    = 1'b0;
        hit_n      = 1'b0;
        miss_n     = 1'b0;
        rd_n       = 1'b0;
        if (clear) begin
            nxt_state = S_IDLE;
            nxt_idx   = '0;
            nxt_len   = LEN_W'(START_LEN);
            nxt_miss  = '0;
            nxt_lead  = 1'b0;
        end else if (load_valid && idle_like) begin
            nxt_seq    = load_data;
            nxt_loaded = 1'b1;
            nxt_state  = S_IDLE;
        end else if (start && idle_like && loaded) begin
            nxt_state = S_PLAY_ON;
            nxt_idx   = '0;
            nxt_len   = LEN_W'(START_LEN);
            nxt_miss  = '0;
            nxt_lead  = 1'b0;
        end else begin
            case (state)
                S_PLAY_ON: if (tick && tcnt == TCNT_W'(NOTE_TICKS - 1)) nxt_state = S_PLAY_GAP;
                S_PLAY_GAP: begin
                    if (tick && tcnt == TCNT_W'(GAP_TICKS - 1)) begin
                        // A lead-in gap precedes a replay and must not advance past note 0.
                        if (lead) begin
                            nxt_lead  = 1'b0;
                            nxt_idx   = '0;
                            nxt_state = S_PLAY_ON;
                        end else if (!last_note) begin
                            nxt_idx   = idx + IDX_W'(1);
                            nxt_state = S_PLAY_ON;
                        end else begin
                            nxt_idx   = '0;
                            nxt_state = S_WAIT_ANS;
                        end
                    end
                end
                S_WAIT_ANS: begin
                    if (ans_valid) begin
                        if (ans_data == seq[idx]) begin
                            hit_n = 1'b1;
                            if (last_note) begin
                                rd_n = 1'b1;
                                if (len_q == LEN_W'(MAX_LEN)) begin
                                    nxt_state = S_WON;
                                end else begin
                                    nxt_len   = len_q + LEN_W'(1);
                                    nxt_idx   = '0;
                                    nxt_lead  = 1'b1;
                                    nxt_state = S_PLAY_GAP;
                                end
                            end else begin
                                nxt_idx = idx + IDX_W'(1);
                                tmr_clr = 1'b1;
                            end
                        end else begin
                            miss_n = 1'b1;
                        end
                    end else if (tick && tcnt == TCNT_W'(ANS_TICKS - 1)) begin
                        miss_n = 1'b1;
                    end
                end
                default: ;
            endcase
            if (miss_n) begin
                if (int'(miss_q) + 1 >= MAX_MISSES) begin
                    nxt_miss  = MISS_W'(MAX_MISSES);
                    nxt_state = S_LOST;
                end else begin
                    nxt_miss  = miss_q + MISS_W'(1);
                    nxt_idx   = '0;
                    nxt_lead  = 1'b1;
                    nxt_state = S_PLAY_GAP;
                end
            end
        end
    end

    logic [NOTE_W-1:0] note_n;
    always_comb begin
        note_n = '0;
        if (nxt_state == S_PLAY_ON) note_n = nxt_seq[nxt_idx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            note_out     <= '0;
            playing      <= 1'b0;
            expect_input <= 1'b0;
            hit          <= 1'b0;
            miss         <= 1'b0;
            round_done   <= 1'b0;
            game_won     <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            note_out     <= note_n;
            playing      <= (nxt_state == S_PLAY_ON) || (nxt_state == S_PLAY_GAP);
            expect_input <= (nxt_state == S_WAIT_ANS);
            hit          <= hit_n;
            miss         <= miss_n;
            round_done   <= rd_n;
            game_won     <= (nxt_state == S_WON);
            game_over    <= (nxt_state == S_LOST);
        end
    end

    assign cur_len    = len_q;
    assign miss_count = miss_q;
endmodule

// File: tb/tb_echo_sequence_engine.sv
// Bench for echo_sequence_engine: control-priority vector table, scripted game scenarios,
// and random games scored against a game-rule model.
module tb_echo_sequence_engine;
    localparam int NOTE_W = 4, MAX_LEN = 8, START_LEN = 3, MAX_MISSES = 3;
    localparam int LEN_W = 4, MISS_W = 2;
    localparam int NOTE_CYC = 6, GAP_CYC = 3, ANS_CYC = 48;
    localparam int R_CONT = 0, R_REPLAY = 1, R_WON = 2, R_LOST = 3;

    logic clk, reset, load_valid, start, clear, ans_valid;
    logic [NOTE_W*MAX_LEN-1:0] load_data;
    logic [NOTE_W-1:0] ans_data, note_out;
    logic playing, expect_input, hit, miss, round_done, game_won, game_over;
    logic [LEN_W-1:0] cur_len;
    logic [MISS_W-1:0] miss_count;

    echo_sequence_engine dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .start(start), .clear(clear), .ans_valid(ans_valid), .ans_data(ans_data),
        .note_out(note_out), .playing(playing), .expect_input(expect_input),
        .hit(hit), .miss(miss), .round_done(round_done), .game_won(game_won),
        .game_over(game_over), .cur_len(cur_len), .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0, n_errs = 0;
    int m_seq[MAX_LEN];
    int m_len, m_miss, m_pos;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic m_load(input logic [31:0] d);
        for (int i = 0; i < MAX_LEN; i++) m_seq[i] = int'(d[i*NOTE_W +: NOTE_W]);
    endtask

    task automatic load(input logic [31:0] d);
        load_valid = 1'b1; load_data = d; step(); load_valid = 1'b0;
        m_load(d);
        chk("load_idle", {game_won, game_over, playing}, 0);
    endtask

    task automatic start_game();
        start = 1'b1; step(); start = 1'b0;
        m_len = START_LEN; m_miss = 0; m_pos = 0;
        chk("start_miss_cnt", miss_count, 0);
        chk("start_len", cur_len, START_LEN);
    endtask

    // Current cycle is the first cycle of the play phase (lead-in gap if lead).
    task automatic expect_play(input int len, input bit lead);
        if (lead) for (int c = 0; c < GAP_CYC; c++) begin
            chk("lead_note", note_out, 0);
            chk("lead_play", playing, 1);
            if (c > 0) chk("pulse_len", {hit, miss, round_done}, 0);
            step();
        end
        for (int i = 0; i < len; i++) begin
            for (int c = 0; c < NOTE_CYC; c++) begin
                chk($sformatf("note%0d", i), note_out, m_seq[i]);
                chk("play_on", playing, 1);
                step();
            end
            for (int c = 0; c < GAP_CYC; c++) begin
                chk($sformatf("gap%0d", i), note_out, 0);
                chk("play_gap", playing, 1);
                step();
            end
        end
        chk("expect_input", expect_input, 1);
        chk("play_done", playing, 0);
        chk("play_len", cur_len, len);
        m_pos = 0;
    endtask

    task automatic check_outcome(input bit eh, input bit em, input bit erd, input int res);
        chk("hit", hit, eh);
        chk("miss", miss, em);
        chk("round_done", round_done, erd);
        chk("miss_count", miss_count, m_miss);
        chk("cur_len", cur_len, m_len);
        chk("game_won", game_won, res == R_WON);
        chk("game_over", game_over, res == R_LOST);
        chk("expect_after", expect_input, res == R_CONT);
        chk("playing_after", playing, res == R_REPLAY);
    endtask

    task automatic answer(input int v, output int res);
        bit eh, erd;
        eh = (v == m_seq[m_pos]); erd = 1'b0; res = R_CONT;
        if (eh) begin
            if (m_pos == m_len - 1) begin
                erd = 1'b1;
                if (m_len == MAX_LEN) res = R_WON;
                else begin m_len++; res = R_REPLAY; end
            end else m_pos++;
        end else begin
            m_miss++;
            res = (m_miss == MAX_MISSES) ? R_LOST : R_REPLAY;
        end
        ans_valid = 1'b1; ans_data = v[NOTE_W-1:0]; step(); ans_valid = 1'b0;
        check_outcome(eh, !eh, erd, res);
    endtask

    // Current cycle is the first WAIT_ANS cycle.
    task automatic timeout(output int res);
        int early = 0;
        for (int k = 0; k < ANS_CYC - 1; k++) begin
            step();
            if (!expect_input || miss) early++;
        end
        chk("timeout_hold", early, 0);
        step();
        m_miss++;
        res = (m_miss == MAX_MISSES) ? R_LOST : R_REPLAY;
        check_outcome(1'b0, 1'b1, 1'b0, res);
    endtask

    task automatic rand_game();
        int res, v, n;
        start_game();
        expect_play(m_len, 1'b0);
        res = R_CONT; n = 0;
        while (res != R_WON && res != R_LOST && n < 60) begin
            repeat ($urandom_range(0, 2)) step();
            if ($urandom_range(0, 99) < 90) v = m_seq[m_pos];
            else v = m_seq[m_pos] ^ int'($urandom_range(1, 15));
            answer(v, res);
            n++;
            if (res == R_REPLAY) expect_play(m_len, 1'b1);
        end
        chk("rand_game_end", int'(res == R_WON || res == R_LOST), 1);
    endtask

    typedef struct {
        bit clr, ld, st, av;
        logic [NOTE_W-1:0] ad;
        logic [31:0] ldat;
        int e_note, e_play, e_exp, e_hit, e_miss;
    } vec_t;
    vec_t tv[9];

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int res;
        reset = 1'b0; load_valid = 1'b0; load_data = '0; start = 1'b0;
        clear = 1'b0; ans_valid = 1'b0; ans_data = '0;
        #22;
        chk("rst_outs", {note_out, playing, expect_input, hit, miss, round_done, game_won, game_over}, 0);
        chk("rst_len", cur_len, START_LEN);
        chk("rst_miss", miss_count, 0);
        @(negedge clk); reset = 1'b1;
        step();

        // clr ld st av ad ldat | note play exp hit miss
        tv[0] = '{0,0,1,0,4'h0,32'h0,        0,0,0,0,0};  // start without a sequence
        tv[1] = '{0,0,0,1,4'h1,32'h0,        0,0,0,0,0};  // answer while idle
        tv[2] = '{0,1,1,0,4'h0,32'h87654321, 0,0,0,0,0};  // load wins over start
        tv[3] = '{0,0,1,0,4'h0,32'h0,        1,1,0,0,0};  // start plays note 0
        tv[4] = '{0,1,0,0,4'h0,32'hFFFFFFFF, 1,1,0,0,0};  // load during play ignored
        tv[5] = '{0,0,0,1,4'h1,32'h0,        1,1,0,0,0};  // answer during play ignored
        tv[6] = '{1,0,1,0,4'h0,32'h0,        0,0,0,0,0};  // clear beats start
        tv[7] = '{0,0,1,0,4'h0,32'h0,        1,1,0,0,0};  // kept sequence replays
        tv[8] = '{1,0,0,0,4'h0,32'h0,        0,0,0,0,0};
        for (int i = 0; i < 9; i++) begin
            clear = tv[i].clr; load_valid = tv[i].ld; start = tv[i].st;
            ans_valid = tv[i].av; ans_data = tv[i].ad; load_data = tv[i].ldat;
            step();
            chk($sformatf("tv%0d_note", i), note_out, tv[i].e_note);
            chk($sformatf("tv%0d_play", i), playing, tv[i].e_play);
            chk($sformatf("tv%0d_exp", i), expect_input, tv[i].e_exp);
            chk($sformatf("tv%0d_hit", i), hit, tv[i].e_hit);
            chk($sformatf("tv%0d_miss", i), miss, tv[i].e_miss);
            chk($sformatf("tv%0d_len", i), cur_len, START_LEN);
        end
        clear = 0; load_valid = 0; start = 0; ans_valid = 0;
        m_load(32'h87654321);

        // Correct round grows to 4 notes.
        start_game(); expect_play(3, 1'b0);
        answer(1, res); answer(2, res); answer(3, res);
        chk("round1_res", res, R_REPLAY);
        expect_play(4, 1'b1);
        clear = 1'b1; step(); clear = 1'b0;
        chk("clr_state", {playing, expect_input, game_over}, 0);
        chk("clr_len", cur_len, START_LEN);

        // Wrong answer, timeout, wrong answer -> LOST.
        start_game(); expect_play(3, 1'b0);
        answer(1, res); answer(5, res);
        expect_play(3, 1'b1);
        timeout(res);
        expect_play(3, 1'b1);
        answer(7, res);
        chk("lost_res", res, R_LOST);
        chk("lost_note", note_out, 0);
        ans_valid = 1'b1; ans_data = 4'h9; step(); step(); ans_valid = 1'b0;
        chk("lost_hold", game_over, 1);
        chk("lost_no_miss", miss, 0);
        chk("lost_sat", miss_count, MAX_MISSES);

        // Start from LOST replays; clear mid WAIT_ANS keeps the sequence.
        start_game(); expect_play(3, 1'b0);
        answer(1, res);
        clear = 1'b1; step(); clear = 1'b0;
        chk("clr_wait", {expect_input, playing, hit}, 0);
        chk("clr_wait_miss", miss_count, 0);
        start_game(); expect_play(3, 1'b0);

        // Perfect game through cur_len = MAX_LEN.
        for (int k = 0; k < 50 && res != R_WON; k++) begin
            answer(m_seq[m_pos], res);
            if (res == R_REPLAY) expect_play(m_len, 1'b1);
        end
        chk("won_res", res, R_WON);
        step(); step();
        chk("won_hold", game_won, 1);
        chk("won_note", note_out, 0);
        load_valid = 1'b1; start = 1'b1; load_data = 32'h2468ACE1; step();
        load_valid = 1'b0; start = 1'b0;
        m_load(32'h2468ACE1);
        chk("ld_st_won", {game_won, playing, expect_input}, 0);
        start_game(); expect_play(3, 1'b0);

        // Asynchronous reset in the middle of a note.
        clear = 1'b1; step(); clear = 1'b0;
        start_game(); step(); step();
        #2 reset = 1'b0;
        #1;
        chk("arst_outs", {note_out, playing, expect_input, hit, miss, round_done, game_won, game_over}, 0);
        chk("arst_len", cur_len, START_LEN);
        #2 reset = 1'b1;
        step();
        start = 1'b1; step(); start = 1'b0;
        chk("arst_unloaded", playing, 0);

        for (int g = 0; g < 6; g++) begin
            load($urandom);
            rand_game();
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
